// File: rtl/adder_accumulator.sv
// ---------------------------------------------------------------------------
// adder_accumulator
//
// Operand-issue and result-capture stage around an external combinational
// WIDTH-bit adder. A packet of operand beats is folded into an accumulator,
// one beat per cycle, adding or subtracting each beat. Carry-out and signed
// overflow from the adder are OR-ed into sticky flags for the packet. The
// packet total is then offered on a valid/ready output handshake.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand beat handshake
//   in_data               operand
//   in_sub                1 = subtract in_data, 0 = add
//   in_last               final beat of the packet
//   add_a/add_b/add_cin   drive to the external adder
//   add_s/add_cout/add_ovf  adder result (combinational from add_a/b/cin)
//   out_valid/out_ready   result handshake
//   out_sum               packet total (modulo 2^WIDTH)
//   out_carry             sticky OR of add_cout over the packet (raw carry,
//                         so a subtract beat with no borrow reports 1)
//   out_ovf               sticky OR of add_ovf over the packet
//   out_count             beats in the packet, saturating at 2^COUNT_W-1
// ---------------------------------------------------------------------------
module adder_accumulator #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sub,
    input  logic               in_last,

    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_cout,
    input  logic               add_ovf,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_carry,
    output logic               out_ovf,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic               carry_st;
    logic               ovf_st;
    logic [COUNT_W-1:0] count;

    logic               beat;
    logic               carry_next;
    logic               ovf_next;
    logic [COUNT_W-1:0] count_next;

    // Beat counter increment that holds at the all-ones maximum.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // Issue: subtraction is acc + ~in_data + 1, so the adder sees the
    // two's-complement negation without any extra logic here.
    assign add_a   = acc;
    assign add_b   = in_sub ? ~in_data : in_data;
    assign add_cin = in_sub;

    // Ready is forced low while reset is held, not only after the first edge.
    assign in_ready = (state == ACC) && !rst;
    assign beat     = in_valid && in_ready;

    assign carry_next = carry_st | add_cout;
    assign ovf_next   = ovf_st | add_ovf;
    assign count_next = sat_inc(count);

    // Capture: accumulator/flags update on each beat; the result registers
    // are loaded on the last beat so they already include it when DONE
    // is entered, and are cleared again on the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            carry_st  <= 1'b0;
            ovf_st    <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (beat) begin
                        acc      <= add_s;
                        carry_st <= carry_next;
                        ovf_st   <= ovf_next;
                        count    <= count_next;
                        if (in_last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= add_s;
                            out_carry <= carry_next;
                            out_ovf   <= ovf_next;
                            out_count <= count_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACC;
                        acc       <= '0;
                        carry_st  <= 1'b0;
                        ovf_st    <= 1'b0;
                        count     <= '0;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_carry <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_count <= '0;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule
